// File: rtl/hid_bus_pkg.sv
// Shared types and widths for the HID bus arbiter: request fields, in-flight tag
// and the read/write classification helper.
package hid_bus_pkg;

  localparam int HID_ADDR_W = 20;
  localparam int HID_DATA_W = 64;
  localparam int HID_WE_W   = 8;
  localparam int STARVE_W   = 4;

  typedef struct packed {
    logic [HID_WE_W-1:0]   we;
    logic [HID_ADDR_W-1:0] addr;
    logic [HID_DATA_W-1:0] wdata;
  } hid_req_t;

  typedef struct packed {
    logic valid;
    logic id;
    logic is_read;
  } hid_tag_t;

  // An op with no byte enables set is a read.
  function automatic logic is_read_op(input logic [HID_WE_W-1:0] we);
    return (we == 8'h00);
  endfunction

endpackage

// File: rtl/hid_arb_sel.sv
// Grant selection between the CPU bridge (r0, priority) and the secondary engine
// (r1), with a saturating counter that forces r1 through after STARVE_LIMIT losses.
module hid_arb_sel
  import hid_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic r0_valid_i,
  input  logic r1_valid_i,
  output logic g0_o,
  output logic g1_o
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt_q;
  logic [STARVE_W-1:0] starve_cnt_d;
  logic                g0_s;
  logic                g1_s;

  // Same-cycle grant and next starvation count.
  always_comb begin
    g1_s         = r1_valid_i & (~r0_valid_i | (starve_cnt_q == LIMIT));
    g0_s         = r0_valid_i & ~g1_s;
    starve_cnt_d = starve_cnt_q;
    if (!r1_valid_i) begin
      starve_cnt_d = 4'd0;
    end else if (g1_s) begin
      starve_cnt_d = 4'd0;
    end else if (g0_s && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign g0_o = g0_s;
  assign g1_o = g1_s;

endmodule

// File: rtl/hid_bus_arb.sv
// Two-requester HID bus arbiter: registers each granted op onto the bus and routes
// the read data returned one cycle later back to the issuer, two cycles after accept.
module hid_bus_arb
  import hid_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = HID_ADDR_W,
  parameter int DATA_W       = HID_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [7:0]        r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_rdata,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [7:0]        r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_rdata,
  output logic              hid_en,
  output logic [7:0]        hid_we,
  output logic [ADDR_W-1:0] hid_addr,
  output logic [DATA_W-1:0] hid_wrdata,
  input  logic [DATA_W-1:0] hid_rddata
);

  logic g0_s;
  logic g1_s;

  logic              hid_en_q,     hid_en_d;
  logic [7:0]        hid_we_q,     hid_we_d;
  logic [ADDR_W-1:0] hid_addr_q,   hid_addr_d;
  logic [DATA_W-1:0] hid_wrdata_q, hid_wrdata_d;
  hid_tag_t          tag_a_q,      tag_a_d;
  hid_tag_t          tag_b_q,      tag_b_d;

  logic              r0_rsp_valid_q, r0_rsp_valid_d;
  logic [DATA_W-1:0] r0_rsp_rdata_q, r0_rsp_rdata_d;
  logic              r1_rsp_valid_q, r1_rsp_valid_d;
  logic [DATA_W-1:0] r1_rsp_rdata_q, r1_rsp_rdata_d;
  logic [DATA_W-1:0] rsp_data_s;

  hid_arb_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_sel (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .r0_valid_i (r0_valid),
    .r1_valid_i (r1_valid),
    .g0_o       (g0_s),
    .g1_o       (g1_s)
  );

  // Nothing is accepted while reset is held, so ready must not advertise it.
  assign r0_ready = g0_s & ~rst_i;
  assign r1_ready = g1_s & ~rst_i;

  // Stage A bus capture and tag pipe advance.
  always_comb begin
    hid_en_d     = 1'b0;
    hid_we_d     = 8'h00;
    hid_addr_d   = hid_addr_q;
    hid_wrdata_d = hid_wrdata_q;
    tag_a_d      = '0;
    if (g1_s) begin
      hid_en_d     = 1'b1;
      hid_we_d     = r1_we;
      hid_addr_d   = r1_addr;
      hid_wrdata_d = r1_wdata;
      tag_a_d      = '{valid: 1'b1, id: 1'b1, is_read: is_read_op(r1_we)};
    end else if (g0_s) begin
      hid_en_d     = 1'b1;
      hid_we_d     = r0_we;
      hid_addr_d   = r0_addr;
      hid_wrdata_d = r0_wdata;
      tag_a_d      = '{valid: 1'b1, id: 1'b0, is_read: is_read_op(r0_we)};
    end else begin
      hid_en_d = 1'b0;
      hid_we_d = 8'h00;
      tag_a_d  = '0;
    end
    tag_b_d = tag_a_q;
  end

  // Response routing: write acks carry zero data; the idle side keeps its last data.
  always_comb begin
    rsp_data_s     = tag_b_q.is_read ? hid_rddata : '0;
    r0_rsp_valid_d = 1'b0;
    r0_rsp_rdata_d = r0_rsp_rdata_q;
    r1_rsp_valid_d = 1'b0;
    r1_rsp_rdata_d = r1_rsp_rdata_q;
    if (tag_b_q.valid) begin
      if (tag_b_q.id) begin
        r1_rsp_valid_d = 1'b1;
        r1_rsp_rdata_d = rsp_data_s;
      end else begin
        r0_rsp_valid_d = 1'b1;
        r0_rsp_rdata_d = rsp_data_s;
      end
    end else begin
      r0_rsp_valid_d = 1'b0;
      r1_rsp_valid_d = 1'b0;
    end
  end

  // Bus, tag pipe and response registers; reset drops anything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hid_en_q       <= 1'b0;
      hid_we_q       <= 8'h00;
      hid_addr_q     <= '0;
      hid_wrdata_q   <= '0;
      tag_a_q        <= '0;
      tag_b_q        <= '0;
      r0_rsp_valid_q <= 1'b0;
      r0_rsp_rdata_q <= '0;
      r1_rsp_valid_q <= 1'b0;
      r1_rsp_rdata_q <= '0;
    end else begin
      hid_en_q       <= hid_en_d;
      hid_we_q       <= hid_we_d;
      hid_addr_q     <= hid_addr_d;
      hid_wrdata_q   <= hid_wrdata_d;
      tag_a_q        <= tag_a_d;
      tag_b_q        <= tag_b_d;
      r0_rsp_valid_q <= r0_rsp_valid_d;
      r0_rsp_rdata_q <= r0_rsp_rdata_d;
      r1_rsp_valid_q <= r1_rsp_valid_d;
      r1_rsp_rdata_q <= r1_rsp_rdata_d;
    end
  end

  assign hid_en       = hid_en_q;
  assign hid_we       = hid_we_q;
  assign hid_addr     = hid_addr_q;
  assign hid_wrdata   = hid_wrdata_q;
  assign r0_rsp_valid = r0_rsp_valid_q;
  assign r0_rsp_rdata = r0_rsp_rdata_q;
  assign r1_rsp_valid = r1_rsp_valid_q;
  assign r1_rsp_rdata = r1_rsp_rdata_q;

endmodule

// File: tb/tb_hid_bus_arb.sv
// Directed bench for hid_bus_arb: single read, write ack, contention, pipelining,
// reset mid-flight and r1-alone, with hand-computed expectations.
module tb_hid_bus_arb;

  localparam int AW = 20;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_valid, r0_ready, r0_rsp_valid;
  logic [7:0]    r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rsp_rdata;
  logic          r1_valid, r1_ready, r1_rsp_valid;
  logic [7:0]    r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rsp_rdata;
  logic          hid_en;
  logic [7:0]    hid_we;
  logic [AW-1:0] hid_addr;
  logic [DW-1:0] hid_wrdata, hid_rddata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hid_bus_arb #(.STARVE_LIMIT(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .r0_valid     (r0_valid),
    .r0_ready     (r0_ready),
    .r0_we        (r0_we),
    .r0_addr      (r0_addr),
    .r0_wdata     (r0_wdata),
    .r0_rsp_valid (r0_rsp_valid),
    .r0_rsp_rdata (r0_rsp_rdata),
    .r1_valid     (r1_valid),
    .r1_ready     (r1_ready),
    .r1_we        (r1_we),
    .r1_addr      (r1_addr),
    .r1_wdata     (r1_wdata),
    .r1_rsp_valid (r1_rsp_valid),
    .r1_rsp_rdata (r1_rsp_rdata),
    .hid_en       (hid_en),
    .hid_we       (hid_we),
    .hid_addr     (hid_addr),
    .hid_wrdata   (hid_wrdata),
    .hid_rddata   (hid_rddata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    r0_valid = 1'b0; r0_we = 8'h00; r0_addr = '0; r0_wdata = '0;
    r1_valid = 1'b0; r1_we = 8'h00; r1_addr = '0; r1_wdata = '0;
    hid_rddata = '0;
    tick();
    tick();
    check_eq("rst_hid_en", 64'(hid_en), 64'd0);
    check_eq("rst_hid_we", 64'(hid_we), 64'd0);
    check_eq("rst_r0_rsp", 64'(r0_rsp_valid), 64'd0);
    check_eq("rst_r1_rsp", 64'(r1_rsp_valid), 64'd0);
    check_eq("rst_starve", 64'(dut.u_sel.starve_cnt_q), 64'd0);
    rst = 1'b0;

    // Single read from the mouse region by r0
    r0_valid = 1'b1; r0_we = 8'h00; r0_addr = 20'h30000;
    #1;
    check_eq("rd_r0_ready", 64'(r0_ready), 64'd1);
    check_eq("rd_r1_ready", 64'(r1_ready), 64'd0);
    tick();
    check_eq("rd_hid_en", 64'(hid_en), 64'd1);
    check_eq("rd_hid_addr", 64'(hid_addr), 64'h30000);
    check_eq("rd_hid_we", 64'(hid_we), 64'd0);
    r0_valid = 1'b0;
    tick();
    check_eq("rd_hid_en_drop", 64'(hid_en), 64'd0);
    check_eq("rd_rsp_early", 64'(r0_rsp_valid), 64'd0);
    hid_rddata = 64'h1_0000_0ABC;
    tick();
    check_eq("rd_rsp_valid", 64'(r0_rsp_valid), 64'd1);
    check_eq("rd_rsp_rdata", r0_rsp_rdata, 64'h1_0000_0ABC);
    check_eq("rd_r1_rsp", 64'(r1_rsp_valid), 64'd0);
    hid_rddata = '0;
    tick();
    check_eq("rd_rsp_once", 64'(r0_rsp_valid), 64'd0);

    // Write by r1 alone: ack with zero data even if the bus returns garbage
    r1_valid = 1'b1; r1_we = 8'hFF; r1_addr = 20'h34000; r1_wdata = '0;
    #1;
    check_eq("wr_r1_ready", 64'(r1_ready), 64'd1);
    check_eq("wr_r0_ready", 64'(r0_ready), 64'd0);
    tick();
    check_eq("wr_hid_en", 64'(hid_en), 64'd1);
    check_eq("wr_hid_we", 64'(hid_we), 64'hFF);
    check_eq("wr_starve", 64'(dut.u_sel.starve_cnt_q), 64'd0);
    r1_valid = 1'b0; r1_we = 8'h00;
    tick();
    check_eq("wr_hid_en_drop", 64'(hid_en), 64'd0);
    check_eq("wr_hid_we_drop", 64'(hid_we), 64'd0);
    hid_rddata = 64'hDEAD_BEEF_0000_1111;
    tick();
    check_eq("wr_r1_rsp", 64'(r1_rsp_valid), 64'd1);
    check_eq("wr_r1_rdata", r1_rsp_rdata, 64'd0);
    check_eq("wr_r0_rsp", 64'(r0_rsp_valid), 64'd0);
    check_eq("wr_r0_hold", r0_rsp_rdata, 64'h1_0000_0ABC);
    hid_rddata = '0;
    tick();
    check_eq("wr_rsp_once", 64'(r1_rsp_valid), 64'd0);

    // Contention: r0,r0,r0,r0,r1 repeating with STARVE_LIMIT=4
    r0_valid = 1'b1; r0_we = 8'h00; r0_addr = 20'h00100;
    r1_valid = 1'b1; r1_we = 8'h00; r1_addr = 20'h00200;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq($sformatf("cont_r1_%0d", i), 64'(r1_ready), (i % 5 == 4) ? 64'd1 : 64'd0);
      check_eq($sformatf("cont_r0_%0d", i), 64'(r0_ready), (i % 5 == 4) ? 64'd0 : 64'd1);
      if (i == 4) check_eq("cont_starve_lim", 64'(dut.u_sel.starve_cnt_q), 64'd4);
      tick();
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (3) tick();

    // Pipelining: three back-to-back r0 reads, in-order responses
    r0_valid = 1'b1; r0_addr = 20'h00000;
    tick();
    check_eq("pipe_addr0", 64'(hid_addr), 64'h00000);
    r0_addr = 20'h08000;
    tick();
    check_eq("pipe_addr1", 64'(hid_addr), 64'h08000);
    r0_addr = 20'h38000;
    hid_rddata = 64'hD0D0_0000_0000_0001;
    tick();
    check_eq("pipe_addr2", 64'(hid_addr), 64'h38000);
    check_eq("pipe_v0", 64'(r0_rsp_valid), 64'd1);
    check_eq("pipe_d0", r0_rsp_rdata, 64'hD0D0_0000_0000_0001);
    r0_valid = 1'b0;
    hid_rddata = 64'hD1D1_0000_0000_0002;
    tick();
    check_eq("pipe_v1", 64'(r0_rsp_valid), 64'd1);
    check_eq("pipe_d1", r0_rsp_rdata, 64'hD1D1_0000_0000_0002);
    hid_rddata = 64'hD2D2_0000_0000_0003;
    tick();
    check_eq("pipe_v2", 64'(r0_rsp_valid), 64'd1);
    check_eq("pipe_d2", r0_rsp_rdata, 64'hD2D2_0000_0000_0003);
    hid_rddata = '0;
    tick();
    check_eq("pipe_end", 64'(r0_rsp_valid), 64'd0);

    // Reset one cycle after an accept, with the starvation counter non-zero
    r0_valid = 1'b1; r0_addr = 20'h01000;
    r1_valid = 1'b1; r1_addr = 20'h02000;
    tick();
    tick();
    check_eq("mid_starve_pre", 64'(dut.u_sel.starve_cnt_q), 64'd2);
    check_eq("mid_hid_en_pre", 64'(hid_en), 64'd1);
    rst = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    #1;
    check_eq("mid_hid_en", 64'(hid_en), 64'd0);
    check_eq("mid_hid_addr", 64'(hid_addr), 64'd0);
    check_eq("mid_r0_rdata", r0_rsp_rdata, 64'd0);
    check_eq("mid_r0_rsp", 64'(r0_rsp_valid), 64'd0);
    check_eq("mid_starve", 64'(dut.u_sel.starve_cnt_q), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    hid_rddata = 64'h5555_5555_5555_5555;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("post_r0_rsp_%0d", i), 64'(r0_rsp_valid), 64'd0);
      check_eq($sformatf("post_r1_rsp_%0d", i), 64'(r1_rsp_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hid_bus_arb.md
Name: hid_bus_arb

Overview:
- Two-requester arbiter for the HID register/framebuffer bus (hid_en/hid_we/hid_addr/hid_wrdata/hid_rddata) that feeds the keyboard FIFO, mouse FIFO and frame store.
- Requester 0 is the CPU bridge and has priority. Requester 1 is a secondary engine (cursor/blit DMA).
- The arbiter registers every bus cycle and routes the read data returned one cycle later back to the issuing requester.
- Starvation of requester 1 is bounded by a limit counter.

Parameters:
- STARVE_LIMIT, 4, max consecutive r0 grants while r1 waits before r1 is forced through (1..15).
- ADDR_W, 20, HID bus address width.
- DATA_W, 64, HID bus data width.

Ports:
- clk_i  in  1  bus clock.
- rst_i  in  1  reset, asynchronous, active-high.
- r0_valid  in  1  requester 0 has a bus op.
- r0_ready  out  1  requester 0 op accepted this cycle.
- r0_we  in  8  byte write enables; 0 = read.
- r0_addr  in  ADDR_W  address.
- r0_wdata  in  DATA_W  write data.
- r0_rsp_valid  out  1  response (read data or write ack) for requester 0.
- r0_rsp_rdata  out  DATA_W  read data; 0 for writes.
- r1_valid, r1_ready, r1_we, r1_addr, r1_wdata, r1_rsp_valid, r1_rsp_rdata: same as r0_* for requester 1.
- hid_en  out  1  bus cycle strobe.
- hid_we  out  8  bus byte enables.
- hid_addr  out  ADDR_W  bus address.
- hid_wrdata  out  DATA_W  bus write data.
- hid_rddata  in  DATA_W  bus read data, valid the cycle after hid_en.

Behaviour:
- Reset values:
  - All outputs 0.
  - Starvation counter 0.
  - In-flight tag pipe cleared.
  - Asserting rst_i mid-operation discards in-flight ops: no rsp_valid follows.
- Grant logic (combinational, same cycle):
  - g1 = r1_valid & (~r0_valid | starve_cnt == STARVE_LIMIT).
  - g0 = r0_valid & ~g1.
  - rN_ready = gN; at most one is high.
- Starvation counter:
  - Increments on a g0 cycle while r1_valid is high, saturating at STARVE_LIMIT.
  - Clears on a g1 cycle, or on any cycle with r1_valid low.
- Stage A (edge E, accept):
  - If g0|g1: hid_en<=1, and hid_we/hid_addr/hid_wrdata <= the granted requester's fields.
  - Tag pipe stage A <= {1, id}.
  - Otherwise hid_en<=0 and hid_we<=0; addr/data hold their last value.
- Stage B (edge E+1): tag moves to stage B. The bus presents hid_rddata during cycle E+1..E+2.
- Response (edge E+2):
  - rID_rsp_valid<=1 for exactly one cycle.
  - rID_rsp_rdata <= (we captured==0) ? hid_rddata : 0.
  - The other requester's rsp_valid<=0 and its rsp_rdata holds.
- Latency and throughput:
  - Accept-to-response latency is 2 cycles; back-to-back accepts give one response per cycle, in order.
  - Requesters must not assume ready while valid is low.
  - A requester holds valid and fields stable until ready.
- Side-effecting writes (FIFO pops, mouse FIFO reset) are issued exactly once per accepted op. The arbiter never replays.
- Simultaneous r0 and r1 with starve_cnt < limit: r0 wins and the counter increments.
- Limit reached: r1 wins that cycle, the counter goes to 0, and r0 waits one cycle.

Decomposition:
- Package hid_bus_pkg:
  - HID_ADDR_W and HID_DATA_W.
  - typedef hid_req_t {we, addr, wdata}.
  - typedef hid_tag_t {valid, id, is_read}.
- One sub-module, hid_arb_sel: grant combinational logic plus starvation counter.
- Bus register and tag pipe stay in the top.

Test Plan:
- Single read: r0 read addr 20'h30000 (mouse region), bus returns 64'h1_0000_0ABC at E+1 -> r0_rsp_valid at E+2, rdata=64'h1_0000_0ABC, r1_rsp_valid stays 0.
- Write ack: r1 write we=8'hFF addr 20'h34000 data 0 -> hid_en=1, hid_we=8'hFF for exactly one cycle, r1_rsp_valid at E+2, rdata=0.
- Contention with STARVE_LIMIT=4: r0 and r1 valid continuously -> grant sequence r0,r0,r0,r0,r1 repeating; r1 never waits more than 5 cycles.
- Pipelining: r0 issues 3 back-to-back reads to addrs 0x0,0x8000,0x38000, bus returns D0,D1,D2 -> 3 consecutive rsp_valid cycles with D0,D1,D2 in order.
- Reset mid-flight: assert rst_i one cycle after an accept -> all outputs 0 immediately; no rsp_valid after reset release; starve_cnt=0.
- r1 alone with r0 idle -> r1_ready same cycle as r1_valid; starve_cnt stays 0.
